memory_unit: RTL and testbench

Byte-addressed 256 x 8 data memory that acts as the responder on the processor's memory address bus. It samples the address driven by the memory address register together with a read or write command and write data from the datapath. It performs the access after a programmable number of wait states and returns read data with a one-cycle `ready` pulse. The control unit stalls on `ready`, so the memory latency can be changed without touching the sequencer.

---
 rtl/memory_unit.sv | 124 ++++++++++++
 tb/tb_memory_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - 256 x 8 data memory responder with programmable wait states
module memory_unit #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Address_bus,
    input  logic [7:0] data_in,
    input  logic       read,
    input  logic       write,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       op_wr_q, op_wr_d;
    logic [7:0] dout_q, dout_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic       mem_we;

    logic [7:0] mem_q [256];

    // Next-state and output logic; address and data are frozen at acceptance
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_wr_d = op_wr_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (read ^ write) begin
                    addr_d  = Address_bus;
                    wdata_d = data_in;
                    op_wr_d = write;
                    cnt_d   = WAIT_LOAD;
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end else if (read && write) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // A reset on this edge must leave storage untouched
                if (op_wr_q) begin
                    mem_we = ~reset;
                end else begin
                    dout_d = mem_q[addr_q];
                end
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            op_wr_q <= 1'b0;
            dout_q  <= 8'h00;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign data_out = dout_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - scoreboard bench for memory_unit at two wait-state settings
module tb_memory_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Address_bus;
    logic [7:0] data_in;
    logic       read;
    logic       write;
    logic       use0;

    logic       rd2, wr2, rd0, wr0;
    logic [7:0] dout2, dout0;
    logic       ready2, ready0, busy2, busy0, err2, err0;
    logic [7:0] cur_dout;
    logic       cur_ready, cur_busy, cur_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model   [2][256];
    logic [7:0] last_rd [2];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    assign rd2 = read  & ~use0;
    assign wr2 = write & ~use0;
    assign rd0 = read  &  use0;
    assign wr0 = write &  use0;

    assign cur_dout  = use0 ? dout0  : dout2;
    assign cur_ready = use0 ? ready0 : ready2;
    assign cur_busy  = use0 ? busy0  : busy2;
    assign cur_err   = use0 ? err0   : err2;

    memory_unit #(.WAIT_STATES(2)) u_dut2 (
        .clk(clk), .reset(reset), .Address_bus(Address_bus), .data_in(data_in),
        .read(rd2), .write(wr2), .data_out(dout2), .ready(ready2), .busy(busy2), .err(err2)
    );

    memory_unit #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .Address_bus(Address_bus), .data_in(data_in),
        .read(rd0), .write(wr0), .data_out(dout0), .ready(ready0), .busy(busy0), .err(err0)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mem_op(input bit is_wr, input logic [7:0] a, input logic [7:0] d, input bit scramble);
        int n;
        int exp_lat;
        logic [7:0] e;
        exp_lat = use0 ? 2 : 4;
        @(negedge clk);
        Address_bus = a;
        data_in     = d;
        read        = ~is_wr;
        write       = is_wr;
        if (is_wr) model[use0][a] = d;
        else       exp_q.push_back(model[use0][a]);
        @(posedge clk);
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
        check_val("busy_accept", cur_busy, 1);
        if (scramble) begin
            Address_bus = a + 8'd1;
            data_in     = 8'hFF;
        end
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!cur_ready && n < 20);
        check_val("latency", n, exp_lat);
        check_val("busy_done", cur_busy, 0);
        if (!is_wr) begin
            e = exp_q.pop_front();
            check_val("rdata", cur_dout, e);
            last_rd[use0] = e;
        end else begin
            check_val("wr_dout_hold", cur_dout, last_rd[use0]);
        end
        @(negedge clk);
        check_val("ready_clear", cur_ready, 0);
    endtask

    task automatic idle_watch(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (cur_ready) seen++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        reset = 1'b1;
        Address_bus = 8'h00;
        data_in = 8'h00;
        read = 1'b0;
        write = 1'b0;
        use0 = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            model[0][i] = 8'h00;
            model[1][i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_dout2", dout2, 8'h00);
        check_val("rst_ready2", ready2, 0);
        check_val("rst_busy2", busy2, 0);
        check_val("rst_err2", err2, 0);
        check_val("rst_dout0", dout0, 8'h00);
        check_val("rst_ready0", ready0, 0);
        check_val("rst_busy0", busy0, 0);
        check_val("rst_err0", err0, 0);

        // write then read with two wait states
        mem_op(1'b1, 8'h3C, 8'hA5, 1'b0);
        mem_op(1'b0, 8'h3C, 8'h00, 1'b0);

        // inputs changing during WAIT have no effect
        mem_op(1'b1, 8'h10, 8'h77, 1'b0);
        mem_op(1'b0, 8'h10, 8'h00, 1'b1);
        mem_op(1'b1, 8'h20, 8'h55, 1'b1);
        mem_op(1'b0, 8'h20, 8'h00, 1'b0);

        // simultaneous read and write
        @(negedge clk);
        Address_bus = 8'h3C;
        data_in = 8'h00;
        read = 1'b1;
        write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("err_pulse", cur_err, 1);
        check_val("err_busy", cur_busy, 0);
        check_val("err_ready", cur_ready, 0);
        read = 1'b0;
        write = 1'b0;
        @(negedge clk);
        check_val("err_clear", cur_err, 0);
        idle_watch(6, seen);
        check_val("err_no_ready", seen, 0);
        mem_op(1'b0, 8'h3C, 8'h00, 1'b0);

        // reset during WAIT of a write discards it
        mem_op(1'b1, 8'h40, 8'h12, 1'b0);
        @(negedge clk);
        Address_bus = 8'h40;
        data_in = 8'h99;
        write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
        check_val("rstw_busy", cur_busy, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_val("rstw_busy_clr", cur_busy, 0);
        check_val("rstw_ready", cur_ready, 0);
        check_val("rstw_dout", cur_dout, 8'h00);
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        idle_watch(6, seen);
        check_val("rstw_no_ready", seen, 0);
        mem_op(1'b0, 8'h40, 8'h00, 1'b0);

        // zero wait states and address extremes
        use0 = 1'b1;
        mem_op(1'b1, 8'h00, 8'h5A, 1'b0);
        mem_op(1'b1, 8'hFF, 8'h3C, 1'b0);
        mem_op(1'b0, 8'hFF, 8'h00, 1'b0);
        mem_op(1'b0, 8'h00, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
